regfile_btn_ctrl: RTL and testbench

Front-panel controller that turns three debounced push-buttons plus address/data switches into sequenced operations on the register file: single write, single read to the display, and a full clear sweep. Sits between the per-button debouncers and the register file; it is the only writer of the register file and owns its read port. One operation runs at a time; presses arriving while busy are dropped.

---
 rtl/regfile_ctrl_pkg.sv | 31 +++
 rtl/regfile_btn_ctrl_if.sv | 24 ++
 rtl/edge_detect.sv | 19 +
 rtl/regfile_btn_ctrl.sv | 131 +++++++++++++
 tb/tb_regfile_btn_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the front-panel register-file controller and the
// register file it drives.
package regfile_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_CLEAR
  } state_e;

  // Op codes ordered by priority: a higher value wins when presses coincide.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  function automatic op_e pick_op(input logic clr, input logic wr, input logic rd);
    if (clr)     return OP_CLR;
    else if (wr) return OP_WR;
    else if (rd) return OP_RD;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/regfile_btn_ctrl_if.sv
// Register-file port bundle: controller is master (write port + read address),
// register file is slave (returns read data one cycle after the address).
interface regfile_btn_ctrl_if
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;

  modport master (
    output rf_we, rf_waddr, rf_wdata, rf_raddr,
    input  rf_rdata
  );

  modport slave (
    input  rf_we, rf_waddr, rf_wdata, rf_raddr,
    output rf_rdata
  );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for a debounced button level. The previous-level flop
// resets high so a button held through reset yields no press.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic prev_q, prev_d;

  always_comb prev_d = level;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= prev_d;
  end

  assign pulse = level & ~prev_q;
endmodule

// File: rtl/regfile_btn_ctrl.sv
// Front-panel controller: sequences single write, single read-to-display and
// full clear sweep on the register file from button presses.
module regfile_btn_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_wr,
  input  logic                      btn_rd,
  input  logic                      btn_clr,
  input  logic [ADDR_W-1:0]         sw_addr,
  input  logic [DATA_W-1:0]         sw_data,
  regfile_btn_ctrl_if.master        rf,
  output logic [ADDR_W-1:0]         disp_addr,
  output logic [DATA_W-1:0]         disp_data,
  output logic                      busy
);
  // Highest register address (NUM_REGS-1) is all ones.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic wr_p, rd_p, clr_p;

  edge_detect u_ed_wr  (.clk(clk), .rst(rst), .level(btn_wr),  .pulse(wr_p));
  edge_detect u_ed_rd  (.clk(clk), .rst(rst), .level(btn_rd),  .pulse(rd_p));
  edge_detect u_ed_clr (.clk(clk), .rst(rst), .level(btn_clr), .pulse(clr_p));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  op_e               op;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    raddr_d     = raddr_q;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    we          = 1'b0;
    waddr       = '0;
    wdata       = '0;
    op          = OP_NONE;
    unique case (state_q)
      ST_IDLE: begin
        op = pick_op(clr_p, wr_p, rd_p);
        unique case (op)
          OP_CLR: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
          OP_WR: begin
            state_d = ST_WRITE;
            addr_d  = sw_addr;
            data_d  = sw_data;
          end
          OP_RD: begin
            // Read address is driven from the press so it is valid at N+1.
            state_d = ST_RD_ADDR;
            addr_d  = sw_addr;
            raddr_d = sw_addr;
          end
          default: ;
        endcase
      end
      ST_WRITE: begin
        we          = 1'b1;
        waddr       = addr_q;
        wdata       = data_q;
        disp_addr_d = addr_q;
        disp_data_d = data_q;
        state_d     = ST_IDLE;
      end
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        disp_addr_d = addr_q;
        disp_data_d = rf.rf_rdata;
        state_d     = ST_IDLE;
      end
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          disp_addr_d = '0;
          disp_data_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      raddr_q     <= '0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
    end
  end

  assign rf.rf_we    = we;
  assign rf.rf_waddr = waddr;
  assign rf.rf_wdata = wdata;
  assign rf.rf_raddr = raddr_q;
  assign disp_addr   = disp_addr_q;
  assign disp_data   = disp_data_q;
  assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_regfile_btn_ctrl.sv
// Directed bench for regfile_btn_ctrl with a 1-cycle-latency register file model.
module tb_regfile_btn_ctrl;
  logic       clk;
  logic       rst;
  logic       btn_wr, btn_rd, btn_clr;
  logic [2:0] sw_addr;
  logic [7:0] sw_data;
  logic [2:0] disp_addr;
  logic [7:0] disp_data;
  logic       busy;

  regfile_btn_ctrl_if #(.DATA_W(8), .ADDR_W(3)) rf ();

  regfile_btn_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_wr(btn_wr), .btn_rd(btn_rd), .btn_clr(btn_clr),
    .sw_addr(sw_addr), .sw_data(sw_data),
    .rf(rf),
    .disp_addr(disp_addr), .disp_data(disp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [8];
  logic [7:0] rdata_q;
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rdata_q = 8'h00;
  end
  always @(posedge clk) begin
    if (rf.rf_we) mem[rf.rf_waddr] <= rf.rf_wdata;
    rdata_q <= mem[rf.rf_raddr];
  end
  assign rf.rf_rdata = rdata_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    btn_wr = 1'b1; sw_addr = a; sw_data = d;
    tick();
    btn_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input logic [2:0] a, output logic [7:0] d);
    btn_rd = 1'b1; sw_addr = a;
    tick();
    btn_rd = 1'b0;
    tick();
    tick();
    tick();
    d = disp_data;
  endtask

  typedef struct {
    logic       wr, rd, clr;
    logic [2:0] a;
    logic [7:0] d;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra;
    logic [2:0] da;
    logic [7:0] dd;
    logic       bz;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0] rv;
    int         we_cnt;

    //            wr rd clr a  d      we wa wd     ra da dd     bz
    vecs[0]  = '{0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    vecs[1]  = '{1, 0, 0, 3, 8'hA5, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    vecs[2]  = '{1, 0, 0, 5, 8'h11, 1, 3, 8'hA5, 0, 0, 8'h00, 1};
    vecs[3]  = '{0, 0, 0, 3, 8'h00, 0, 0, 8'h00, 0, 3, 8'hA5, 0};
    vecs[4]  = '{1, 0, 0, 5, 8'h3C, 0, 0, 8'h00, 0, 3, 8'hA5, 0};
    vecs[5]  = '{0, 0, 0, 5, 8'h3C, 1, 5, 8'h3C, 0, 3, 8'hA5, 1};
    vecs[6]  = '{0, 1, 0, 3, 8'h00, 0, 0, 8'h00, 0, 5, 8'h3C, 0};
    vecs[7]  = '{0, 1, 0, 7, 8'h00, 0, 0, 8'h00, 3, 5, 8'h3C, 1};
    vecs[8]  = '{0, 0, 0, 7, 8'h00, 0, 0, 8'h00, 3, 5, 8'h3C, 1};
    vecs[9]  = '{1, 1, 0, 1, 8'h77, 0, 0, 8'h00, 3, 3, 8'hA5, 0};
    vecs[10] = '{0, 0, 0, 2, 8'h00, 1, 1, 8'h77, 3, 3, 8'hA5, 1};
    vecs[11] = '{0, 0, 0, 2, 8'h00, 0, 0, 8'h00, 3, 1, 8'h77, 0};
    vecs[12] = '{0, 0, 0, 2, 8'h00, 0, 0, 8'h00, 3, 1, 8'h77, 0};

    btn_wr = 0; btn_rd = 0; btn_clr = 0; sw_addr = '0; sw_data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Write, write, read, then simultaneous wr+rd (write wins).
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d_we", i),    32'(rf.rf_we),    32'(vecs[i].we));
      chk($sformatf("v%0d_waddr", i), 32'(rf.rf_waddr), 32'(vecs[i].wa));
      chk($sformatf("v%0d_wdata", i), 32'(rf.rf_wdata), 32'(vecs[i].wd));
      chk($sformatf("v%0d_raddr", i), 32'(rf.rf_raddr), 32'(vecs[i].ra));
      chk($sformatf("v%0d_daddr", i), 32'(disp_addr),   32'(vecs[i].da));
      chk($sformatf("v%0d_ddata", i), 32'(disp_data),   32'(vecs[i].dd));
      chk($sformatf("v%0d_busy", i),  32'(busy),        32'(vecs[i].bz));
      btn_wr = vecs[i].wr; btn_rd = vecs[i].rd; btn_clr = vecs[i].clr;
      sw_addr = vecs[i].a; sw_data = vecs[i].d;
      tick();
    end
    btn_wr = 0; btn_rd = 0; btn_clr = 0;
    tick();

    // Full clear with a wr press at N+1 that must be dropped.
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'(8'h11 * (i + 1)));
    do_read(3'd6, rv);
    chk("fill_read6", 32'(rv), 32'h77);
    btn_clr = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr%0d_we", i),    32'(rf.rf_we),    32'd1);
      chk($sformatf("clr%0d_waddr", i), 32'(rf.rf_waddr), 32'(i));
      chk($sformatf("clr%0d_wdata", i), 32'(rf.rf_wdata), 32'd0);
      chk($sformatf("clr%0d_busy", i),  32'(busy),        32'd1);
      if (i == 0) begin
        btn_clr = 1'b0; btn_wr = 1'b1; sw_addr = 3'd2; sw_data = 8'hFF;
      end
      if (i == 1) btn_wr = 1'b0;
      tick();
    end
    chk("clr_end_busy",  32'(busy),      32'd0);
    chk("clr_end_we",    32'(rf.rf_we),  32'd0);
    chk("clr_end_daddr", 32'(disp_addr), 32'd0);
    chk("clr_end_ddata", 32'(disp_data), 32'd0);
    we_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      we_cnt += int'(rf.rf_we);
      tick();
    end
    chk("clr_dropped_wr", 32'(we_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), rv);
      chk($sformatf("clr_read%0d", i), 32'(rv), 32'd0);
    end

    // clr+wr together: only the clear runs.
    do_write(3'd4, 8'h99);
    btn_clr = 1'b1; btn_wr = 1'b1; sw_addr = 3'd4; sw_data = 8'h5A;
    tick();
    btn_clr = 1'b0; btn_wr = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cw%0d_waddr", i), 32'(rf.rf_waddr), 32'(i));
      chk($sformatf("cw%0d_wdata", i), 32'(rf.rf_wdata), 32'd0);
      we_cnt += int'(rf.rf_we);
      tick();
    end
    chk("cw_we_count", 32'(we_cnt),    32'd8);
    chk("cw_busy",     32'(busy),      32'd0);
    chk("cw_daddr",    32'(disp_addr), 32'd0);
    chk("cw_ddata",    32'(disp_data), 32'd0);
    tick();
    chk("cw_mem4",     32'(mem[4]),    32'd0);

    // Button held through reset release: no write until released and re-pressed.
    btn_wr = 1'b1; sw_addr = 3'd6; sw_data = 8'h66;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      we_cnt += int'(rf.rf_we);
      tick();
    end
    chk("hold_no_write", 32'(we_cnt), 32'd0);
    chk("hold_busy",     32'(busy),   32'd0);
    btn_wr = 1'b0;
    tick();
    btn_wr = 1'b1;
    tick();
    btn_wr = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      we_cnt += int'(rf.rf_we);
      tick();
    end
    chk("hold_one_write", 32'(we_cnt), 32'd1);
    chk("hold_mem6",      32'(mem[6]), 32'h66);

    // Reset during a clear leaves a partial clear and reset-valued outputs.
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'(8'hA0 + i));
    do_read(3'd7, rv);
    chk("pre_rst_read7", 32'(rv), 32'hA7);
    btn_clr = 1'b1;
    tick();
    btn_clr = 1'b0;
    tick();
    tick();
    chk("prc_waddr2", 32'(rf.rf_waddr), 32'd2);
    rst = 1'b1;
    tick();
    chk("prc_we",    32'(rf.rf_we),    32'd0);
    chk("prc_waddr", 32'(rf.rf_waddr), 32'd0);
    chk("prc_wdata", 32'(rf.rf_wdata), 32'd0);
    chk("prc_raddr", 32'(rf.rf_raddr), 32'd0);
    chk("prc_daddr", 32'(disp_addr),   32'd0);
    chk("prc_ddata", 32'(disp_data),   32'd0);
    chk("prc_busy",  32'(busy),        32'd0);
    rst = 1'b0;
    tick();
    chk("prc_we_after", 32'(rf.rf_we), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("prc_mem%0d", i), 32'(mem[i]), (i < 3) ? 32'd0 : 32'(8'hA0 + i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
